// File: rtl/fltadd_ctrl_if.sv
// rtl/fltadd_ctrl_if.sv - data memory and float adder handshake bundle for fltadd_ctrl
interface fltadd_ctrl_if;
  logic [7:0]  mem_addr;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;
  logic        fa_start;
  logic [15:0] fa_a;
  logic [15:0] fa_b;
  logic        fa_valid;
  logic [15:0] fa_result;

  modport master (
    output mem_addr, mem_wr_en, mem_wr_data, fa_start, fa_a, fa_b,
    input  mem_rd_data, fa_valid, fa_result
  );

  modport slave (
    input  mem_addr, mem_wr_en, mem_wr_data, fa_start, fa_a, fa_b,
    output mem_rd_data, fa_valid, fa_result
  );
endinterface

// File: rtl/fltadd_ctrl.sv
// rtl/fltadd_ctrl.sv - sequencer for one half-precision add through shared data memory
module fltadd_ctrl #(
  parameter logic [7:0] BASE_ADDR  = 8'd128,
  parameter int          TIMEOUT    = 16,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic             error,
  fltadd_ctrl_if.master    bus
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [15:0]   QNAN     = 16'h7E00;

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_LAUNCH, S_WAIT, S_WR_HI, S_WR_LO, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_addr_q, mem_addr_d;
  logic          mem_wr_en_q, mem_wr_en_d;
  logic [7:0]    mem_wr_data_q, mem_wr_data_d;
  logic          fa_start_q, fa_start_d;
  logic [15:0]   fa_a_q, fa_a_d;
  logic [15:0]   fa_b_q, fa_b_d;
  logic [15:0]   result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          auto_armed_q, auto_armed_d;

  // Outputs are registered, so each transition loads the values of the state being entered.
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = 8'h00;
    mem_wr_en_d   = 1'b0;
    mem_wr_data_d = 8'h00;
    fa_start_d    = 1'b0;
    fa_a_d        = fa_a_q;
    fa_b_d        = fa_b_q;
    result_d      = result_q;
    cnt_d         = cnt_q;
    done_d        = done_q;
    error_d       = error_q;
    auto_armed_d  = auto_armed_q;

    case (state_q)
      S_IDLE: begin
        if (start || auto_armed_q) begin
          state_d      = S_RD0;
          mem_addr_d   = BASE_ADDR;
          auto_armed_d = 1'b0;
          done_d       = 1'b0;
          error_d      = 1'b0;
        end
      end
      S_RD0: begin
        fa_a_d[15:8] = bus.mem_rd_data;
        mem_addr_d   = BASE_ADDR + 8'd1;
        state_d      = S_RD1;
      end
      S_RD1: begin
        fa_a_d[7:0] = bus.mem_rd_data;
        mem_addr_d  = BASE_ADDR + 8'd2;
        state_d     = S_RD2;
      end
      S_RD2: begin
        fa_b_d[15:8] = bus.mem_rd_data;
        mem_addr_d   = BASE_ADDR + 8'd3;
        state_d      = S_RD3;
      end
      S_RD3: begin
        fa_b_d[7:0] = bus.mem_rd_data;
        fa_start_d  = 1'b1;
        state_d     = S_LAUNCH;
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.fa_valid) begin
          result_d      = bus.fa_result;
          mem_addr_d    = BASE_ADDR + 8'd4;
          mem_wr_en_d   = 1'b1;
          mem_wr_data_d = bus.fa_result[15:8];
          state_d       = S_WR_HI;
        end else if (cnt_q == CNT_LAST) begin
          result_d      = QNAN;
          error_d       = 1'b1;
          mem_addr_d    = BASE_ADDR + 8'd4;
          mem_wr_en_d   = 1'b1;
          mem_wr_data_d = QNAN[15:8];
          state_d       = S_WR_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_HI: begin
        mem_addr_d    = BASE_ADDR + 8'd5;
        mem_wr_en_d   = 1'b1;
        mem_wr_data_d = result_q[7:0];
        state_d       = S_WR_LO;
      end
      S_WR_LO: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d    = S_RD0;
          mem_addr_d = BASE_ADDR;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_addr_q    <= 8'h00;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= 8'h00;
      fa_start_q    <= 1'b0;
      fa_a_q        <= 16'h0000;
      fa_b_q        <= 16'h0000;
      result_q      <= 16'h0000;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      auto_armed_q  <= AUTO_START;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      fa_start_q    <= fa_start_d;
      fa_a_q        <= fa_a_d;
      fa_b_q        <= fa_b_d;
      result_q      <= result_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      error_q       <= error_d;
      auto_armed_q  <= auto_armed_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.fa_start    = fa_start_q;
  assign bus.fa_a        = fa_a_q;
  assign bus.fa_b        = fa_b_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_fltadd_ctrl.sv
// tb/tb_fltadd_ctrl.sv - randomized model-checked bench for fltadd_ctrl
module tb_fltadd_ctrl;
  localparam logic [7:0] BASE = 8'd128;
  localparam int         TMO  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic done, error;
  fltadd_ctrl_if bus ();

  fltadd_ctrl #(.BASE_ADDR(BASE), .TIMEOUT(TMO), .AUTO_START(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .error(error), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:255];
  int          cyc = 0;
  int          due = -1;
  logic [15:0] fa_val = 16'h0000;
  int          total = 0;
  int          bad = 0;
  bit          keep_stale = 1'b0;
  int          next_k = 1;
  logic [15:0] next_res = 16'h0000;
  int          wr_log [$];

  assign bus.mem_rd_data = mem[bus.mem_addr];
  assign bus.fa_valid    = (cyc == due);
  assign bus.fa_result   = fa_val;

  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Run-level model: a run is a go cycle plus a wait length; every output follows from the offset.
  bit          m_rst = 1'b0, m_active = 1'b0, m_armed = 1'b0, m_to = 1'b0;
  int          m_go = 0, m_w = 0, m_k = 0;
  logic [15:0] m_res_in = 0, m_res = 0, m_a = 0, m_b = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_rst = 1'b1; m_active = 1'b0; m_armed = 1'b1;
      if (!keep_stale) due <= -1;
    end else begin
      m_rst = 1'b0;
      if ((!m_active || (cyc - m_go >= 8 + m_w)) && (start || m_armed)) begin
        m_go = cyc; m_active = 1'b1; m_armed = 1'b0;
        m_k = next_k; m_res_in = next_res;
        m_to = (next_k < 1 || next_k > TMO);
        m_w = m_to ? TMO : next_k;
        m_res = m_to ? 16'h7E00 : next_res;
        m_a = {mem[BASE], mem[BASE + 8'd1]};
        m_b = {mem[BASE + 8'd2], mem[BASE + 8'd3]};
      end
      if (bus.fa_start) begin
        due    <= (m_k == 0) ? -1 : cyc + m_k;
        fa_val <= m_res_in;
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = cyc - m_go;
    if (m_rst) begin
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wr_en", bus.mem_wr_en, 0);
      chk("rst_wr_data", bus.mem_wr_data, 0);
      chk("rst_fa_start", bus.fa_start, 0);
      chk("rst_fa_a", bus.fa_a, 0);
      chk("rst_fa_b", bus.fa_b, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
    end else if (m_active) begin
      chk("wr_en", bus.mem_wr_en, (n == 6 + m_w) || (n == 7 + m_w));
      chk("fa_start", bus.fa_start, n == 5);
      chk("done", done, n >= 8 + m_w);
      chk("error", error, (n >= 6 + m_w) && m_to);
      if (n >= 1 && n <= 4) chk("rd_addr", bus.mem_addr, BASE + 8'(n - 1));
      if (n >= 5 && n <= 7 + m_w) begin
        chk("fa_a", bus.fa_a, m_a);
        chk("fa_b", bus.fa_b, m_b);
      end
      if (n == 6 + m_w) begin
        chk("wr_hi_addr", bus.mem_addr, BASE + 8'd4);
        chk("wr_hi_data", bus.mem_wr_data, m_res[15:8]);
      end
      if (n == 7 + m_w) begin
        chk("wr_lo_addr", bus.mem_addr, BASE + 8'd5);
        chk("wr_lo_data", bus.mem_wr_data, m_res[7:0]);
      end
    end else begin
      chk("idle_wr_en", bus.mem_wr_en, 0);
      chk("idle_fa_start", bus.fa_start, 0);
      chk("idle_done", done, 0);
    end
    if (bus.mem_wr_en === 1'b1) wr_log.push_back(cyc);
  end

  int t0, lat;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc, output int l);
    l = -1;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (done === 1'b1) begin
        l = cyc - t0;
        break;
      end
    end
    if (l < 0) begin
      total++; bad++;
      $display("FAIL done_wait: no done within %0d cycles (cycle %0d)", maxc, cyc);
    end
  endtask

  task automatic load_ops(input logic [7:0] a1, a0, b1, b0);
    mem[BASE] <= a1; mem[BASE + 8'd1] <= a0;
    mem[BASE + 8'd2] <= b1; mem[BASE + 8'd3] <= b0;
    mem[BASE + 8'd4] <= 8'hAA; mem[BASE + 8'd5] <= 8'hAA;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k0, gap;
    bit ok;
    logic [15:0] r0, expv;

    // Nominal add
    load_ops(8'h1A, 8'h04, 8'h1A, 8'h04);
    next_k = 3; next_res = 16'h1E04;
    repeat (3) step();
    reset = 1'b0; t0 = cyc;
    wait_done(60, lat);
    chk("nominal_lat", lat, 11);
    chk("nominal_hi", mem[132], 8'h1E);
    chk("nominal_lo", mem[133], 8'h04);
    chk("nominal_err", error, 0);

    // Minimum latency
    do_reset();
    load_ops(8'h40, 8'h00, 8'h40, 8'h00);
    next_k = 1; next_res = 16'h4204;
    wr_log.delete();
    reset = 1'b0; t0 = cyc;
    wait_done(60, lat);
    chk("minlat_lat", lat, 9);
    chk("minlat_nwr", wr_log.size(), 2);
    chk("minlat_wr0", (wr_log.size() > 0) ? wr_log[0] - t0 : -1, 7);
    chk("minlat_wr1", (wr_log.size() > 1) ? wr_log[1] - t0 : -1, 8);
    chk("minlat_hi", mem[132], 8'h42);
    chk("minlat_lo", mem[133], 8'h04);

    // Timeout
    do_reset();
    load_ops(8'h3C, 8'h00, 8'hBC, 8'h00);
    next_k = 0; next_res = 16'h1234;
    reset = 1'b0; t0 = cyc;
    wait_done(80, lat);
    chk("timeout_lat", lat, 24);
    chk("timeout_err", error, 1);
    chk("timeout_hi", mem[132], 8'h7E);
    chk("timeout_lo", mem[133], 8'h00);

    // Reset mid-WAIT with a stale adder answer arriving during the next run's reads
    do_reset();
    load_ops(8'h11, 8'h22, 8'h33, 8'h44);
    next_k = 15; next_res = 16'hBEEF;
    reset = 1'b0; t0 = cyc;
    repeat (7) step();
    reset = 1'b1; keep_stale = 1'b1;
    repeat (10) step();
    chk("abort_hi_untouched", mem[132], 8'hAA);
    chk("abort_lo_untouched", mem[133], 8'hAA);
    next_k = 2; next_res = 16'h5A3C;
    reset = 1'b0; t0 = cyc;
    wait_done(60, lat);
    keep_stale = 1'b0;
    chk("rerun_lat", lat, 10);
    chk("rerun_hi", mem[132], 8'h5A);
    chk("rerun_lo", mem[133], 8'h3C);

    // Start while busy, then restart from DONE
    do_reset();
    load_ops(8'h01, 8'h02, 8'h03, 8'h04);
    next_k = 2; next_res = 16'hC001;
    reset = 1'b0; t0 = cyc;
    repeat (3) step();
    start = 1'b1; step(); start = 1'b0;
    wait_done(60, lat);
    chk("busy_lat", lat, 10);
    chk("busy_hi", mem[132], 8'hC0);
    load_ops(8'h05, 8'h06, 8'h07, 8'h08);
    next_k = 1; next_res = 16'h0BAD;
    step();
    start = 1'b1; t0 = cyc; step(); start = 1'b0;
    chk("restart_done_clr", done, 0);
    chk("restart_err_clr", error, 0);
    wait_done(60, lat);
    chk("restart_lat", lat, 9);
    chk("restart_hi", mem[132], 8'h0B);
    chk("restart_lo", mem[133], 8'hAD);

    // Randomized runs with stray start pulses while busy
    for (int r = 0; r < 30; r++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      load_ops(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      k0 = $urandom_range(0, 20);
      r0 = 16'($urandom);
      next_k = k0; next_res = r0;
      start = 1'b1; t0 = cyc; step(); start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (done === 1'b1) begin
          ok = 1'b1;
          break;
        end
        start = ($urandom_range(0, 3) == 0);
        step();
      end
      start = 1'b0;
      if (!ok) begin
        total++; bad++;
        $display("FAIL rand_done: run %0d never finished (cycle %0d)", r, cyc);
      end
      expv = (k0 == 0 || k0 > TMO) ? 16'h7E00 : r0;
      chk("rand_hi", mem[132], expv[15:8]);
      chk("rand_lo", mem[133], expv[7:0]);
      chk("rand_err", error, (k0 == 0 || k0 > TMO));
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
